// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam int REG_IDX_W      = 5;
    localparam int MD_LATENCY_DEF = 4;

endpackage

// File: rtl/md_freeze_timer.sv
// MUL/DIV freeze sequencer: a start in RUN freezes the front end for MD_LATENCY
// cycles in total (start cycle included); done pulses on the last frozen cycle.
module md_freeze_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done_o  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and MUL/DIV freeze.
// Optional stalled-cycle counter enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_md_start,
    input  logic                 ex_branch_taken,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_bubble,
    output logic                 md_busy,
    output logic                 md_done,
    output logic [15:0]          stall_cycles
);

    logic lu;
    logic md_start;
    logic timer_busy;
    logic timer_done;

    assign lu = id_valid && ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    // A taken branch outranks a MUL/DIV start in the same cycle.
    assign md_start = ex_md_start && !ex_branch_taken;

    md_freeze_timer #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .busy_o  (timer_busy),
        .done_o  (timer_done)
    );

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (timer_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            md_busy  = 1'b1;
            md_done  = timer_done;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_md_start) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            md_busy  = 1'b1;
        end else if (lu) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_en;
        logic        id_ex_bubble;
        logic        md_busy;
        logic        md_done;
        logic [15:0] stall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_mem_read = 1'b0;
    logic       ex_md_start = 1'b0;
    logic       ex_branch_taken = 1'b0;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        md_busy, md_done;
    logic [15:0] stall_cycles;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: frozen cycles still to come after the current one, and the stall tally.
    int   frozen_left = 0;
    int   stall_tally = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_md_start     (ex_md_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
    endtask

    // Drive one cycle of inputs and queue the expected response.
    task automatic cyc(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                       input logic ms, input logic br);
        exp_t e;
        logic hz;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_md_start = ms; ex_branch_taken = br;

        hz = v && mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
              id_ex_bubble: 1'b0, md_busy: 1'b0, md_done: 1'b0, stall: 16'd0};
`ifdef PIPE_HAZARD_PERF_CNT_EN
        e.stall = 16'(stall_tally);
`endif
        if (r) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.id_ex_bubble = 1; e.if_id_flush = 1;
            e.stall = 16'd0;
            frozen_left = 0;
            stall_tally = 0;
        end else begin
            if (frozen_left > 0) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.md_busy = 1;
                e.md_done = (frozen_left == 1);
                frozen_left--;
            end else if (br) begin
                e.if_id_flush = 1; e.id_ex_bubble = 1;
            end else if (ms) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.md_busy = 1;
                frozen_left = MD_LAT - 1;
            end else if (hz) begin
                e.pc_en = 0; e.if_id_en = 0; e.id_ex_bubble = 1;
            end
            if (!e.pc_en && stall_tally < 65535) stall_tally++;
        end
        exp_q.push_back(e);
        $display("cyc rst=%0b br=%0b md=%0b lu=%0b -> pc_en=%0b bubble=%0b flush=%0b md_busy=%0b md_done=%0b",
                 r, br, ms, hz, e.pc_en, e.id_ex_bubble, e.if_id_flush, e.md_busy, e.md_done);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_en",        16'(pc_en),        16'(e.pc_en));
                chk("if_id_en",     16'(if_id_en),     16'(e.if_id_en));
                chk("if_id_flush",  16'(if_id_flush),  16'(e.if_id_flush));
                chk("id_ex_en",     16'(id_ex_en),     16'(e.id_ex_en));
                chk("id_ex_bubble", 16'(id_ex_bubble), 16'(e.id_ex_bubble));
                chk("md_busy",      16'(md_busy),      16'(e.md_busy));
                chk("md_done",      16'(md_done),      16'(e.md_done));
                chk("stall_cycles", stall_cycles,      e.stall);
            end
        end
    end

    initial begin
        int wait_cnt;
        // Reset held two cycles, then defaults.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Load-use on rs1 then the bubble cycle; ex_rd=0 never stalls.
        cyc(0, 1, 3, 0, 1, 0, 3, 1, 0, 0);
        idle();
        cyc(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 7, 5, 0, 1, 5, 1, 0, 0);
        idle();
        // Branch together with load-use.
        cyc(0, 1, 3, 0, 1, 0, 3, 1, 0, 1);
        // MUL/DIV freeze with a branch and load-use during busy, then back-to-back start.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 3, 0, 1, 0, 3, 1, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle(); idle(); idle();
        // Branch outranks a simultaneous MUL/DIV start.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // Reset in the second busy cycle aborts the freeze.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();
        // Load-use plus one MUL/DIV from a clean reset: five stalled cycles.
        cyc(0, 1, 3, 0, 1, 0, 3, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle(); idle(); idle(); idle();
        // Random traffic biased toward register collisions.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0));
        end
        idle();
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
